// File: rtl/led_pattern_gen.sv
// LED pattern source: a prescaled step engine with four animation modes.
// A debounced push-button cycles through the modes.
module led_pattern_gen #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned STEP_DIV  = 6750000,
    parameter int unsigned DB_CYCLES = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             en,
    output logic [WIDTH-1:0] pattern,
    output logic [1:0]       mode,
    output logic             step_tick
);

    localparam int unsigned PscW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PscW-1:0] PscLast = PscW'(STEP_DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ModeCount  = 2'd0,
        ModeShift  = 2'd1,
        ModeBounce = 2'd2,
        ModeFill   = 2'd3
    } mode_e;

    logic             btn_s1_q, btn_s1_d;
    logic             btn_s2_q, btn_s2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [PscW-1:0]  psc_q, psc_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    mode_e            mode_q, mode_d;
    logic             dir_left_q, dir_left_d;
    logic             step_tick_q, step_tick_d;

    logic press;
    logic tick;

    function automatic logic [WIDTH-1:0] init_pattern(input mode_e m);
        if (m == ModeShift || m == ModeBounce) begin
            return WIDTH'(1);
        end
        return '0;
    endfunction

    always_comb begin
        btn_s1_d     = btn;
        btn_s2_d     = btn_s1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        db_cnt_d     = '0;
        psc_d        = psc_q;
        pattern_d    = pattern_q;
        mode_d       = mode_q;
        dir_left_d   = dir_left_q;
        step_tick_d  = 1'b0;

        // Accept a new level only after it has persisted for DB_CYCLES cycles.
        if (btn_s2_q != stable_q) begin
            if (db_cnt_q == DbLast) begin
                stable_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end

        press = stable_q & ~stable_dly_q;
        tick  = en && (psc_q == PscLast);

        if (en) begin
            psc_d = tick ? '0 : psc_q + PscW'(1);
        end

        if (press) begin
            // A press overrides a coincident tick entirely.
            mode_d     = mode_e'(mode_q + 2'd1);
            pattern_d  = init_pattern(mode_d);
            psc_d      = '0;
            dir_left_d = 1'b1;
        end else if (tick) begin
            step_tick_d = 1'b1;
            unique case (mode_q)
                ModeCount: pattern_d = pattern_q + WIDTH'(1);
                ModeShift: pattern_d = (pattern_q << 1) | (pattern_q >> (WIDTH - 1));
                ModeBounce: begin
                    if (dir_left_q) begin
                        if (pattern_q[WIDTH-1]) begin
                            pattern_d  = pattern_q >> 1;
                            dir_left_d = 1'b0;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            pattern_d  = pattern_q << 1;
                            dir_left_d = 1'b1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                end
                ModeFill: pattern_d = (&pattern_q) ? '0 : ((pattern_q << 1) | WIDTH'(1));
                default:  pattern_d = pattern_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q     <= 1'b0;
            btn_s2_q     <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            psc_q        <= '0;
            pattern_q    <= '0;
            mode_q       <= ModeCount;
            dir_left_q   <= 1'b1;
            step_tick_q  <= 1'b0;
        end else begin
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_cnt_q     <= db_cnt_d;
            psc_q        <= psc_d;
            pattern_q    <= pattern_d;
            mode_q       <= mode_d;
            dir_left_q   <= dir_left_d;
            step_tick_q  <= step_tick_d;
        end
    end

    assign pattern   = pattern_q;
    assign mode      = mode_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: index-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button/enable/reset.
module tb_led_pattern_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned DB = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn;
    logic         en;
    logic [W-1:0] pattern;
    logic [1:0]   mode;
    logic         step_tick;

    led_pattern_gen #(
        .WIDTH    (W),
        .STEP_DIV (SD),
        .DB_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .en       (en),
        .pattern  (pattern),
        .mode     (mode),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pattern is a pure function of mode and the number of steps since mode entry.
    int m_mode = 0, m_idx = 0, m_phase = 0, m_run = 0;
    bit m_s1 = 0, m_s2 = 0, m_stable = 0, m_stable_d = 0, m_step = 0;
    bit m_press, m_tick;
    int bpos[6] = '{0, 1, 2, 3, 2, 1};

    function automatic logic [3:0] model_pattern(input int m, input int k);
        case (m)
            0:       return 4'(k % 16);
            1:       return 4'(1 << (k % 4));
            2:       return 4'(1 << bpos[k % 6]);
            default: return 4'((1 << (k % 5)) - 1);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_idx = 0; m_phase = 0; m_run = 0;
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0; m_step = 0;
        end else begin
            m_press    = m_stable && !m_stable_d;
            m_tick     = en && (m_phase == SD - 1);
            m_stable_d = m_stable;
            if (m_s2 != m_stable) begin
                m_run++;
                if (m_run == DB) begin
                    m_stable = m_s2;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
            if (m_press) begin
                m_mode  = (m_mode + 1) % 4;
                m_idx   = 0;
                m_phase = 0;
                m_step  = 0;
            end else begin
                if (en) m_phase = m_tick ? 0 : m_phase + 1;
                if (m_tick) m_idx++;
                m_step = m_tick;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pattern", pattern, model_pattern(m_mode, m_idx));
            check("mode", mode, m_mode);
            check("step_tick", step_tick, m_step);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_hold();
        btn = 1'b1;
        wait_edges(DB + 3);
    endtask

    task automatic release_btn();
        btn = 1'b0;
        wait_edges(DB + 4);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * SD; i++) begin
            if (m_phase == ph) break;
            wait_edges(1);
        end
        check("phase_align", m_phase, ph);
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; en = 1'b0;
        wait_edges(2);
        chk_on = 1'b1;
        check("rst_pattern", pattern, 4'h0);
        check("rst_mode", mode, 2'd0);
        check("rst_tick", step_tick, 1'b0);
        rst = 1'b0; en = 1'b1;

        wait_edges(40);
        check("count_a", pattern, 4'hA);
        check("inv_a", 4'(~pattern), 4'h5);
        check("tick_at_a", step_tick, 1'b1);
        wait_edges(24);
        check("count_wrap", pattern, 4'h0);
        check("inv_wrap", 4'(~pattern), 4'hF);

        btn = 1'b1;
        wait_edges(5);
        btn = 1'b0;
        wait_edges(20);
        check("glitch_mode", mode, 2'd0);

        btn = 1'b1;
        wait_edges(DB + 2);
        check("press_early", mode, 2'd0);
        wait_edges(1);
        check("press_mode", mode, 2'd1);
        check("press_init", pattern, 4'b0001);
        wait_edges(12);
        check("shift_3", pattern, 4'b1000);
        check("held_mode", mode, 2'd1);
        release_btn();

        press_hold();
        check("bounce_mode", mode, 2'd2);
        check("bounce_init", pattern, 4'b0001);
        wait_edges(12);
        check("bounce_msb", pattern, 4'b1000);
        wait_edges(4);
        check("bounce_back", pattern, 4'b0100);
        wait_edges(12);
        check("bounce_lsb_rev", pattern, 4'b0010);
        release_btn();

        press_hold();
        check("fill_mode", mode, 2'd3);
        wait_edges(16);
        check("fill_full", pattern, 4'b1111);
        wait_edges(4);
        check("fill_clear", pattern, 4'b0000);
        release_btn();

        press_hold();
        check("wrap_mode", mode, 2'd0);
        check("wrap_init", pattern, 4'b0000);
        release_btn();

        wait_phase(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            check("frozen_tick", step_tick, 1'b0);
        end
        en = 1'b1;
        wait_edges(1);
        check("resume_1", step_tick, 1'b0);
        wait_edges(1);
        check("resume_2", step_tick, 1'b1);

        // Press lands on the edge 10 cycles after btn rises; phase 1 makes that a tick edge.
        wait_phase(1);
        btn = 1'b1;
        wait_edges(DB + 3);
        check("coll_mode", mode, 2'd1);
        check("coll_init", pattern, 4'b0001);
        check("coll_tick", step_tick, 1'b0);

        wait_edges(6);
        rst = 1'b1; btn = 1'b0;
        wait_edges(1);
        check("mid_rst_pattern", pattern, 4'h0);
        check("mid_rst_mode", mode, 2'd0);
        check("mid_rst_tick", step_tick, 1'b0);
        rst = 1'b0;

        for (int s = 0; s < 70; s++) begin
            int len;
            len = $urandom_range(1, 25);
            btn = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 60) == 0);
            wait_edges(1);
            rst = 1'b0;
            wait_edges(len - 1);
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Upstream pattern source for the 4-bit `inv` stage that drives the board's active-low LEDs.
- Produces an active-high LED pattern; a 1 bit means LED on. `inv` does the polarity flip.
- Steps the pattern at a programmable rate.
- A debounced push-button cycles through four animation modes (counter, rotate, bounce, fill).

Parameters:
- WIDTH, 4: pattern width; must match `inv` width.
- STEP_DIV, 6750000: clk cycles per pattern step (27 MHz / 4 Hz). Must be ≥1.
- DB_CYCLES, 270000: consecutive stable cycles required to accept a button level change (10 ms). Must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn  in  1  raw, asynchronous, active-high push-button.
- en  in  1  step enable; 0 freezes the animation.
- pattern  out  WIDTH  active-high LED pattern to `inv`.
- mode  out  2  current mode: 0 COUNT, 1 SHIFT, 2 BOUNCE, 3 FILL.
- step_tick  out  1  one-cycle pulse, high in the cycle the pattern has just stepped.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Every register updates on the rising clk edge only.
- Reset values: pattern=0, mode=0 (COUNT), step_tick=0, prescaler=0, sync flops=0, debounced level=0, debounce counter=0, bounce direction=left.
- Reset mid-operation: everything takes its reset value on the next edge with rst=1, regardless of any other input.
- Button synchroniser: 2-flop chain, output s2.
- Debounce:
  - When s2 != stable: if cnt == DB_CYCLES-1, then stable<=s2 and cnt<=0; otherwise cnt++.
  - When s2 == stable: cnt<=0.
  - Any glitch shorter than DB_CYCLES cycles at s2 is ignored.
- Press detection: press = stable & ~stable_q, where stable_q is stable delayed one cycle. One pulse per debounced rising edge; a held button never repeats.
- Press latency: btn first sampled high at edge 0 gives mode change at edge DB_CYCLES+2.
- Prescaler:
  - Counts 0..STEP_DIV-1 only while en=1; holds its value while en=0.
  - Internal tick = en && prescaler==STEP_DIV-1; the prescaler wraps to 0 on the tick.
  - With STEP_DIV=1 a tick occurs on every enabled cycle.
- On a tick:
  - pattern takes its next value on that edge.
  - step_tick is registered and goes high for exactly the one cycle in which the new pattern is first visible.
- On a press, in a single edge:
  - mode <= (mode+1) mod 4 (3 wraps to 0).
  - pattern <= initial value of the new mode; prescaler <= 0; bounce direction <= left.
- Press coincident with tick: press wins, the tick is discarded, and step_tick stays 0 in the following cycle.
- Mode sequences (shown for WIDTH=4):
  - COUNT: init 0000; pattern+1, wrapping at 2^WIDTH (1111 -> 0000).
  - SHIFT: init 0001; rotate left: 0001, 0010, 0100, 1000, 0001.
  - BOUNCE: init 0001, direction left; one-hot walks left, reverses at the MSB, walks right, reverses at the LSB.
    - Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
    - The end positions are never repeated.
  - FILL: init 0000; thermometer fill then clear: 0000, 0001, 0011, 0111, 1111, 0000.
- Outputs are driven directly from registers; there is no combinational path from btn or en to any output.

Test Plan (STEP_DIV=4, DB_CYCLES=8; also instantiate `inv` on pattern):
1. rst=1 for 2 cycles, then rst=0, en=1 -> pattern=0, mode=0. step_tick pulses every 4th cycle. pattern counts 1, 2, … F, then 0. `inv` output is 4'hF at pattern 0 and 4'h5 at pattern 4'hA.
2. btn high for 5 cycles, then low -> mode stays 0, no reload, counting continues uninterrupted.
3. btn high for 20 cycles -> mode=1 and pattern=0001 exactly at edge 10 after the first high sample, with no second advance while held. Subsequent ticks give 0010, 0100, 1000, 0001.
4. Further clean presses:
   - Second press -> BOUNCE: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
   - Third press -> FILL: 0000, 0001, 0011, 0111, 1111, 0000.
   - Fourth press -> mode=0, pattern=0000.
5. en=0 for 10 cycles mid-step (prescaler=2) -> no step_tick, pattern held. After en=1, the next tick occurs exactly 2 cycles later.
6. Align the debounced press with the prescaler tick -> mode advances, pattern=init, and step_tick stays 0 that cycle. Then assert rst for 1 cycle mid-sequence -> next edge gives pattern=0, mode=0, step_tick=0.
